siso_frame_ctrl: RTL
====================

Name: siso_frame_ctrl

Overview:
Controller that sequences a serial-in/serial-out shift datapath as a framed serial transmitter. It accepts a parallel word over a valid/ready handshake, holds it in an internal shift register, and drives it out one bit per bit period. A frame strobe marks the data bits, an optional idle gap follows each frame, and a completion pulse marks the end. It sits between a parallel producer and the serial D-FF shift chain and owns all shift timing.

Parameters:
WIDTH, 8, bits per frame (>=2)
BIT_CYCLES, 1, clk cycles each bit is held on ser_out (>=1)
GAP_CYCLES, 1, idle clk cycles after each frame before accepting the next word (>=0)
LSB_FIRST, 0, 0 = MSB shifted out first, 1 = LSB first

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
in_data  input  WIDTH  parallel word to transmit
in_valid  input  1  producer has in_data available
in_ready  output  1  controller can accept a word
abort  input  1  synchronous frame abort, active high
ser_out  output  1  serial data bit
frame  output  1  high while ser_out carries a data bit
busy  output  1  high in SHIFT or GAP
done  output  1  one-cycle pulse after a frame completes normally

Behaviour:
- All outputs registered. While reset=0: state=IDLE; in_ready, ser_out, frame, busy, done=0; shift register, bit counter and cycle counter cleared.
- FSM states: IDLE, SHIFT, GAP.
- IDLE: in_ready=1 from the first rising edge with reset=1. Accept on a rising edge with in_valid=1 and in_ready=1: capture in_data, go to SHIFT, in_ready=0, busy=1. in_valid with in_ready=0 is ignored; no word is latched.
- SHIFT: the handshake occurs in cycle N. The first bit is on ser_out in cycle N+1, with frame=1. Each bit is held exactly BIT_CYCLES cycles. The bit order is in_data[WIDTH-1] down to [0], or [0] up if LSB_FIRST=1. Bit k occupies cycles N+1+k*BIT_CYCLES through N+(k+1)*BIT_CYCLES.
- End of the last bit period: ser_out=0 and frame=0 in the next cycle, and done=1 for exactly that one cycle.
  - GAP_CYCLES>0: enter GAP. done is high in the first GAP cycle. Stay in GAP for GAP_CYCLES cycles, then go to IDLE (in_ready=1, busy=0).
  - GAP_CYCLES=0: go directly to IDLE. done and in_ready are both high in the same cycle.
- Frame-to-frame minimum spacing between accepting handshakes: WIDTH*BIT_CYCLES+GAP_CYCLES+1 cycles.
- Counters: the bit counter is $clog2(WIDTH) bits wide and the cycle counter is $clog2(max(BIT_CYCLES,GAP_CYCLES)+1) bits wide. Both reset to 0 at each bit/gap boundary. There is no wrap past WIDTH-1.
- abort=1 sampled in SHIFT or GAP:
  - next cycle goes to IDLE with ser_out=0, frame=0, busy=0, in_ready=1;
  - no done pulse;
  - the remaining bits are discarded.
- abort in IDLE has no effect. abort and in_valid together in IDLE: abort wins and no word is accepted.
- Reset asserted mid-frame: all outputs go to 0 immediately (asynchronously) and the frame is lost. After release, operation restarts from IDLE.
- ser_out=0 whenever frame=0.

Test Plan:
1. WIDTH=8, BIT_CYCLES=1, GAP=1, LSB_FIRST=0. Accept 8'hA5 in cycle N -> ser_out=1,0,1,0,0,1,0,1 in cycles N+1..N+8. frame=1 for exactly those 8 cycles. done=1 only in N+9. in_ready=1 from N+10.
2. Same configuration, in_valid held high with 8'hA5 then 8'h3C -> second handshake in cycle N+10. 8'h3C bits appear in N+11..N+18. in_valid during busy latches nothing.
3. BIT_CYCLES=3, LSB_FIRST=1, send 8'h01 -> ser_out=1 for cycles N+1..N+3, then 0 for N+4..N+24. frame is high for 24 cycles. done=1 in N+25.
4. GAP=0, send 8'hFF -> ser_out=1 for N+1..N+8. In cycle N+9, done=1 and in_ready=1 together, and a new handshake is accepted in N+9.
5. Assert abort in cycle N+4 of an 8'hA5 frame -> IDLE in N+5 with frame=0, ser_out=0, in_ready=1. No done pulse ever occurs for that frame.
6. Drive reset=0 asynchronously mid-SHIFT -> ser_out, frame, busy, done, in_ready=0 without waiting for clk. After release, in_ready=1 at the first edge. A fresh 8'h5A then transmits correctly.

Source files
------------

// File: rtl/siso_frame_ctrl.sv
// ============================================================================
// siso_frame_ctrl : framed serial transmitter; accepts a word on valid/ready and shifts it out
// Revision: 1.0
// ============================================================================
`default_nettype none

module siso_frame_ctrl #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 1,
  parameter int GAP_CYCLES = 1,
  parameter int LSB_FIRST  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic             ser_out,
  output logic             frame,
  output logic             busy,
  output logic             done
);

  localparam int BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CMAX = (BIT_CYCLES > GAP_CYCLES) ? BIT_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [BW-1:0] BIT_LAST     = BW'(WIDTH - 1);
  localparam logic [CW-1:0] BIT_CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_CYC_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic [CW-1:0]    cyc_cnt;

  // The outgoing bit always sits at the shift-out end of the register.
  function automatic logic out_bit(input logic [WIDTH-1:0] v);
    return (LSB_FIRST != 0) ? v[0] : v[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] shift_on(input logic [WIDTH-1:0] v);
    return (LSB_FIRST != 0) ? (v >> 1) : (v << 1);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      cyc_cnt  <= '0;
      in_ready <= 1'b0;
      ser_out  <= 1'b0;
      frame    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          busy     <= 1'b0;
          frame    <= 1'b0;
          ser_out  <= 1'b0;
          if (in_valid && in_ready && !abort) begin
            state    <= SHIFT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            frame    <= 1'b1;
            ser_out  <= out_bit(in_data);
            shreg    <= shift_on(in_data);
            bit_cnt  <= '0;
            cyc_cnt  <= '0;
          end
        end

        SHIFT: begin
          if (abort) begin
            state    <= IDLE;
            frame    <= 1'b0;
            ser_out  <= 1'b0;
            busy     <= 1'b0;
            in_ready <= 1'b1;
            bit_cnt  <= '0;
            cyc_cnt  <= '0;
          end else if (cyc_cnt == BIT_CYC_LAST) begin
            cyc_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              frame   <= 1'b0;
              ser_out <= 1'b0;
              done    <= 1'b1;
              if (GAP_CYCLES > 0) begin
                state <= GAP;
              end else begin
                state    <= IDLE;
                busy     <= 1'b0;
                in_ready <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              ser_out <= out_bit(shreg);
              shreg   <= shift_on(shreg);
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        GAP: begin
          if (abort || cyc_cnt == GAP_CYC_LAST) begin
            state    <= IDLE;
            cyc_cnt  <= '0;
            busy     <= 1'b0;
            in_ready <= 1'b1;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          frame    <= 1'b0;
          ser_out  <= 1'b0;
          busy     <= 1'b0;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
